// File: rtl/collision_map_if.sv
// Bus between the collision map writer, its requester, the tile ROM and the collision RAM.
// The master side issues start/level and returns ROM data; the slave is the map writer.
interface collision_map_if;
    logic        start;
    logic [1:0]  level;
    logic        busy;
    logic        done;
    logic [10:0] tile_addr;
    logic [7:0]  tile_q;
    logic        map_wren;
    logic [16:0] map_address;
    logic        map_data;

    modport master (
        output start, level, tile_q,
        input  busy, done, tile_addr, map_wren, map_address, map_data
    );

    modport slave (
        input  start, level, tile_q,
        output busy, done, tile_addr, map_wren, map_address, map_data
    );
endinterface

// File: rtl/collision_map_writer.sv
// Expands a level's 20x15 tile map into the 320x240 1-bit collision bitmap (1 = walkable).
// Build macro COLLISION_MAP_BORDER_EN forces the outermost screen pixels to blocked.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; level latched on accept
// S_FETCH | tile_addr driven for (tx,ty)
// S_WAIT  | ROM latency; tile walk bit latched at end of cycle
// S_WRITE | 256 pixel writes of the current tile, row-major within tile
// S_DONE  | one-cycle done pulse, busy drops after it
module collision_map_writer #(
    parameter int TILES_X     = 20,
    parameter int TILES_Y     = 15,
    parameter int LEVEL_TILES = 300,
    parameter int SOLID_BIT   = 7
) (
    input  logic           i_clock,
    input  logic           i_reset,
    collision_map_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      r_state, w_state_nx;
    logic [1:0]  r_level, w_level_nx;
    logic [4:0]  r_tx, w_tx_nx;
    logic [3:0]  r_ty, w_ty_nx;
    logic [3:0]  r_sx, w_sx_nx;
    logic [3:0]  r_sy, w_sy_nx;
    logic        r_walk, w_walk_nx;

    logic        r_busy;
    logic        r_done;
    logic [10:0] r_tile_addr;
    logic        r_map_wren;
    logic [16:0] r_map_address;
    logic        r_map_data;

    logic [8:0]  w_px;
    logic [7:0]  w_py;
    logic [16:0] w_addr;
    logic [10:0] w_tile_addr;
    logic        w_edge;
    logic        w_map_data;

    always_comb begin
        w_state_nx = r_state;
        w_level_nx = r_level;
        w_tx_nx    = r_tx;
        w_ty_nx    = r_ty;
        w_sx_nx    = r_sx;
        w_sy_nx    = r_sy;
        w_walk_nx  = r_walk;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_level_nx = bus.level;
                    w_tx_nx    = '0;
                    w_ty_nx    = '0;
                    w_state_nx = S_FETCH;
                end
            end
            S_FETCH: w_state_nx = S_WAIT;
            S_WAIT: begin
                w_walk_nx  = ~bus.tile_q[SOLID_BIT];
                w_sx_nx    = '0;
                w_sy_nx    = '0;
                w_state_nx = S_WRITE;
            end
            S_WRITE: begin
                w_sx_nx = r_sx + 4'd1;
                if (r_sx == 4'd15) begin
                    w_sy_nx = r_sy + 4'd1;
                    if (r_sy == 4'd15) begin
                        if (r_tx == 5'(TILES_X - 1) && r_ty == 4'(TILES_Y - 1)) begin
                            w_state_nx = S_DONE;
                        end else begin
                            w_state_nx = S_FETCH;
                            if (r_tx == 5'(TILES_X - 1)) begin
                                w_tx_nx = '0;
                                w_ty_nx = r_ty + 4'd1;
                            end else begin
                                w_tx_nx = r_tx + 5'd1;
                            end
                        end
                    end
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from next-cycle values so they line up with the state they belong to.
    assign w_px   = {w_tx_nx, w_sx_nx};
    assign w_py   = {w_ty_nx, w_sy_nx};
    assign w_addr = ({9'd0, w_py} << 8) + ({9'd0, w_py} << 6) + {8'd0, w_px};
    assign w_tile_addr = 11'(w_level_nx) * 11'(LEVEL_TILES)
                       + 11'(w_ty_nx) * 11'(TILES_X)
                       + 11'(w_tx_nx);

`ifdef COLLISION_MAP_BORDER_EN
    assign w_edge = (w_px == 9'd0) || (w_px == 9'd319) || (w_py == 8'd0) || (w_py == 8'd239);
`else
    assign w_edge = 1'b0;
`endif

    assign w_map_data = w_walk_nx & ~w_edge;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_level       <= '0;
            r_tx          <= '0;
            r_ty          <= '0;
            r_sx          <= '0;
            r_sy          <= '0;
            r_walk        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_tile_addr   <= '0;
            r_map_wren    <= 1'b0;
            r_map_address <= '0;
            r_map_data    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_level    <= w_level_nx;
            r_tx       <= w_tx_nx;
            r_ty       <= w_ty_nx;
            r_sx       <= w_sx_nx;
            r_sy       <= w_sy_nx;
            r_walk     <= w_walk_nx;
            r_busy     <= (w_state_nx != S_IDLE);
            r_done     <= (w_state_nx == S_DONE);
            r_map_wren <= (w_state_nx == S_WRITE);
            if (w_state_nx == S_FETCH) begin
                r_tile_addr <= w_tile_addr;
            end
            if (w_state_nx == S_WRITE) begin
                r_map_address <= w_addr;
                r_map_data    <= w_map_data;
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.tile_addr   = r_tile_addr;
    assign bus.map_wren    = r_map_wren;
    assign bus.map_address = r_map_address;
    assign bus.map_data    = r_map_data;

endmodule

// File: tb/tb_collision_map_writer.sv
// Random-ROM bench for collision_map_writer: pixel values, write order and timing against a map model.
// Build with COLLISION_MAP_BORDER_EN defined to expect blocked screen-edge pixels.
module tb_collision_map_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    collision_map_if bus ();

    collision_map_writer dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:1199];

    // Synchronous tile ROM: one cycle of read latency.
    always @(posedge clk) bus.tile_q <= rom[bus.tile_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected pixel value straight from screen geometry.
    function automatic bit exp_pix(input int lvl, input int addr);
        int x, y, t;
        x = addr % 320;
        y = addr / 320;
        t = (y / 16) * 20 + (x / 16);
`ifdef COLLISION_MAP_BORDER_EN
        if (x == 0 || x == 319 || y == 0 || y == 239) return 1'b0;
`endif
        return ~rom[lvl * 300 + t][7];
    endfunction

    // Address of the k-th write: tiles in raster order, pixels row-major inside each tile.
    function automatic int exp_addr(input int k);
        int t, w;
        t = k / 256;
        w = k % 256;
        return ((t / 20) * 16 + w / 16) * 320 + (t % 20) * 16 + (w % 16);
    endfunction

    byte wcnt [76800];
    int  nwrites, bad_order, bad_data, bad_taddr, ndone, done_cyc, busy_after, first_taddr, cyc;

    task automatic clear_stats();
        for (int i = 0; i < 76800; i++) wcnt[i] = 0;
        nwrites = 0; bad_order = 0; bad_data = 0; bad_taddr = 0;
        ndone = 0; done_cyc = -1; busy_after = -1; first_taddr = -1;
    endtask

    // Pulse start, then monitor from FETCH entry (cycle 0) until limit or one cycle past done.
    task automatic run(input int lvl, input int limit, input int repulse_at, input int repulse_lvl);
        int a;
        bus.start = 1'b1;
        bus.level = 2'(lvl);
        @(negedge clk);
        bus.start = 1'b0;
        first_taddr = int'(bus.tile_addr);
        cyc = 0;
        while (cyc < limit) begin
            if (bus.map_wren) begin
                a = int'(bus.map_address);
                if (a != exp_addr(nwrites)) bad_order++;
                if (a < 76800) begin
                    if (bus.map_data != exp_pix(lvl, a)) bad_data++;
                    wcnt[a]++;
                end else begin
                    bad_data++;
                end
                if (nwrites % 256 == 0 && int'(bus.tile_addr) != lvl * 300 + nwrites / 256) bad_taddr++;
                nwrites++;
            end
            if (bus.done) begin
                if (done_cyc < 0) done_cyc = cyc;
                ndone++;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = int'(bus.busy);
            if (cyc == repulse_at) begin
                bus.start = 1'b1;
                bus.level = 2'(repulse_lvl);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (done_cyc >= 0 && cyc == done_cyc + 2) break;
        end
        bus.start = 1'b0;
    endtask

    int lvl_a, lvl_b, exp_partial, bad_cover, late_done;

    initial begin
        for (int i = 0; i < 1200; i++) rom[i] = 8'($urandom);
        bus.start = 1'b0;
        bus.level = 2'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_busy",      int'(bus.busy), 0);
        check("rst_done",      int'(bus.done), 0);
        check("rst_wren",      int'(bus.map_wren), 0);
        check("rst_address",   int'(bus.map_address), 0);
        check("rst_data",      int'(bus.map_data), 0);
        check("rst_tile_addr", int'(bus.tile_addr), 0);

        rst = 1'b0;
        @(negedge clk);

        // Partial pass interrupted by reset after 5000 cycles.
        lvl_a = $urandom_range(0, 3);
        clear_stats();
        run(lvl_a, 5000, -1, 0);
        exp_partial = (5000 / 258) * 256 + ((5000 % 258) > 2 ? (5000 % 258) - 2 : 0);
        check("part_first_taddr", first_taddr, lvl_a * 300);
        check("part_writes",      nwrites, exp_partial);
        check("part_order",       bad_order, 0);
        check("part_data",        bad_data, 0);
        check("part_tile_addr",   bad_taddr, 0);
        check("part_no_done",     ndone, 0);

        rst = 1'b1;
        @(negedge clk);
        check("midrst_wren", int'(bus.map_wren), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        rst = 1'b0;
        late_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.map_wren) late_done++;
        end
        check("midrst_quiet", late_done, 0);

        // Full pass on a non-zero level, with a start re-pulse at another level mid-run.
        lvl_b = $urandom_range(1, 3);
        rom[lvl_b * 300] = 8'h80;
        rom[lvl_b * 300 + 21] = 8'h80;
        rom[((lvl_b + 1) % 4) * 300] = 8'h00;
        clear_stats();
        run(lvl_b, 80000, 1000, (lvl_b + 1) % 4);
        bad_cover = 0;
        for (int i = 0; i < 76800; i++) if (wcnt[i] != 1) bad_cover++;
        check("full_first_taddr", first_taddr, lvl_b * 300);
        check("full_done_cycle",  done_cyc, 77400);
        check("full_done_count",  ndone, 1);
        check("full_writes",      nwrites, 76800);
        check("full_order",       bad_order, 0);
        check("full_data",        bad_data, 0);
        check("full_tile_addr",   bad_taddr, 0);
        check("full_coverage",    bad_cover, 0);
        check("full_busy_after",  busy_after, 0);
        check("full_idle_wren",   int'(bus.map_wren), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
